// File: rtl/led_blink_ctrl.sv
`timescale 1ns/1ps
// LED blink sequencer: turns a one-cycle trigger into blink_num ON/OFF blinks,
// holding busy while running and pulsing done once on normal completion.
module led_blink_ctrl #(
  parameter int N              = 32,
  parameter int FREQ           = 100,
  parameter int ON_TIME        = 100,
  parameter int OFF_TIME       = 100,
  parameter int CNT_W          = 4,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic [CNT_W-1:0] blink_num,
  input  logic             cancel,
  output logic             led_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam longint ON_CYCLES  = longint'(ON_TIME) * 1000 * FREQ;
  localparam longint OFF_CYCLES = longint'(OFF_TIME) * 1000 * FREQ;
  localparam logic [N-1:0] ON_LAST  = N'(ON_CYCLES - 1);
  localparam logic [N-1:0] OFF_LAST = N'(OFF_CYCLES - 1);
  localparam logic LIT   = ~LED_ACTIVE_LOW;
  localparam logic UNLIT = LED_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     timer;
  logic [CNT_W-1:0] remaining;

  assign state_dbg = state;

  // Handshake: trigger is a request with no ready; it is accepted only on an
  // edge where the block is idle, blink_num!=0 and cancel=0, otherwise dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led_out   <= UNLIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger && (blink_num != '0) && !cancel) begin
            state     <= S_ON;
            remaining <= blink_num;
            timer     <= '0;
            busy      <= 1'b1;
            led_out   <= LIT;
          end
        end
        S_ON: begin
          if (cancel) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            led_out   <= UNLIT;
          end else if (timer == ON_LAST) begin
            state     <= S_OFF;
            timer     <= '0;
            led_out   <= UNLIT;
            remaining <= remaining - 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_OFF: begin
          if (cancel) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            led_out   <= UNLIT;
          end else if (timer == OFF_LAST) begin
            timer <= '0;
            // The trailing OFF phase always runs so back-to-back runs stay separated.
            if (remaining != '0) begin
              state   <= S_ON;
              led_out <= LIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          timer     <= '0;
          remaining <= '0;
          busy      <= 1'b0;
          led_out   <= UNLIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
`timescale 1ns/1ps
// Bench for led_blink_ctrl: scenario tasks against a cycle-position model of
// the blink sequence (ON=2000, OFF=1000 cycles).
module tb_led_blink_ctrl;

  localparam int CNT_W = 4;
  localparam int ON_C  = 2000;
  localparam int OFF_C = 1000;
  localparam int PER   = ON_C + OFF_C;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             trigger = 1'b0;
  logic             cancel = 1'b0;
  logic [CNT_W-1:0] blink_num = '0;
  logic             led_out, busy, done;
  logic             led_out_al, busy_al, done_al;
  logic [1:0]       state_dbg, state_dbg_al;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];

  led_blink_ctrl #(.N(32), .FREQ(1), .ON_TIME(2), .OFF_TIME(1), .CNT_W(CNT_W),
                   .LED_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .blink_num(blink_num),
    .cancel(cancel), .led_out(led_out), .busy(busy), .done(done),
    .state_dbg(state_dbg));

  led_blink_ctrl #(.N(32), .FREQ(1), .ON_TIME(2), .OFF_TIME(1), .CNT_W(CNT_W),
                   .LED_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .blink_num(blink_num),
    .cancel(cancel), .led_out(led_out_al), .busy(busy_al), .done(done_al),
    .state_dbg(state_dbg_al));

  // Reference model: a run is just "started with n blinks, k cycles ago".
  bit   m_active = 1'b0;
  int   m_n = 0;
  int   m_k = 0;
  logic exp_busy, exp_led, exp_done;
  assign exp_busy = m_active && (m_k < m_n * PER);
  assign exp_led  = exp_busy && ((m_k % PER) < ON_C);
  assign exp_done = m_active && (m_k == m_n * PER);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (!exp_busy && trigger && (blink_num != 0) && !cancel) begin
      m_active <= 1'b1;
      m_n      <= int'(blink_num);
      m_k      <= 0;
    end else if (exp_busy && cancel) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k >= m_n * PER) m_active <= 1'b0;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      checks++;
      if ({led_out, busy, done, led_out_al} !== 4'b0001) begin
        errors++;
        if (errors <= 20) $display("FAIL reset_idle cyc %0d led/busy/done/led_al got %b%b%b%b exp 0001",
                                   c, led_out, busy, done, led_out_al);
      end
    end
  endtask

  task automatic test_three_blinks();
    int bcnt = 0; int dcnt = 0; int lcnt = 0; int rises = 0; int bad_done = 0;
    logic prev_led = 1'b0; logic prev_busy = 1'b0;
    exp_q.push_back(4'd3);
    trigger = 1'b1; blink_num = 4'd3;
    for (int c = 0; c < 9050; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      checks++;
      if ({led_out, busy, done, led_out_al} !== {exp_led, exp_busy, exp_done, !exp_led}) begin
        errors++;
        if (errors <= 20) $display("FAIL three_blinks cyc %0d led/busy/done/led_al got %b%b%b%b exp %b%b%b%b",
                                   c, led_out, busy, done, led_out_al, exp_led, exp_busy, exp_done, !exp_led);
      end
      bcnt += int'(busy); dcnt += int'(done); lcnt += int'(led_out);
      if (led_out && !prev_led) rises++;
      if (done && !(prev_busy && !busy)) bad_done++;
      prev_led = led_out; prev_busy = busy;
    end
    checks++;
    if (bcnt != 9000) begin errors++; $display("FAIL three_blinks_busy_len got %0d exp 9000", bcnt); end
    checks++;
    if (lcnt != 3 * ON_C) begin errors++; $display("FAIL three_blinks_lit_len got %0d exp %0d", lcnt, 3 * ON_C); end
    checks++;
    if (dcnt != 1 || bad_done != 0) begin errors++; $display("FAIL three_blinks_done got %0d pulses (%0d misplaced) exp 1", dcnt, bad_done); end
    checks++;
    if (rises != int'(exp_q.pop_front())) begin errors++; $display("FAIL three_blinks_count got %0d exp 3", rises); end
  endtask

  task automatic test_blink_zero();
    trigger = 1'b1; blink_num = 4'd0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      // second half: valid trigger masked by simultaneous cancel
      trigger = (c == 0) || (c == 100);
      blink_num = (c == 100) ? 4'd2 : 4'd0;
      cancel = (c == 100);
      checks++;
      if ({led_out, busy, done} !== 3'b000 || exp_busy !== 1'b0) begin
        errors++;
        if (errors <= 20) $display("FAIL blink_zero cyc %0d led/busy/done got %b%b%b exp 000", c, led_out, busy, done);
      end
    end
    trigger = 1'b0; cancel = 1'b0;
  endtask

  task automatic test_ignore_retrigger();
    int bcnt = 0; int dcnt = 0; int rises = 0; logic prev_led = 1'b0;
    exp_q.push_back(4'd2);
    trigger = 1'b1; blink_num = 4'd2;
    for (int c = 0; c < 6050; c++) begin
      @(negedge clk);
      trigger = (c == 500);
      blink_num = (c == 500) ? 4'd5 : 4'd2;
      checks++;
      if ({led_out, busy, done} !== {exp_led, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL ignore_retrigger cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                                   c, led_out, busy, done, exp_led, exp_busy, exp_done);
      end
      bcnt += int'(busy); dcnt += int'(done);
      if (led_out && !prev_led) rises++;
      prev_led = led_out;
    end
    trigger = 1'b0;
    checks++;
    if (bcnt != 6000) begin errors++; $display("FAIL ignore_retrigger_busy_len got %0d exp 6000", bcnt); end
    checks++;
    if (dcnt != 1) begin errors++; $display("FAIL ignore_retrigger_done got %0d exp 1", dcnt); end
    checks++;
    if (rises != int'(exp_q.pop_front())) begin errors++; $display("FAIL ignore_retrigger_count got %0d exp 2", rises); end
  endtask

  task automatic test_cancel();
    int dcnt = 0; int bcnt = 0; int lcnt = 0;
    trigger = 1'b1; blink_num = 4'd4;
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      cancel = (c == 2500);
      checks++;
      if ({led_out, busy, done} !== {exp_led, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL cancel cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                                   c, led_out, busy, done, exp_led, exp_busy, exp_done);
      end
      if (c == 2501) begin
        checks++;
        if ({led_out, busy} !== 2'b00) begin errors++; $display("FAIL cancel_abort got led/busy %b%b exp 00", led_out, busy); end
      end
      dcnt += int'(done);
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL cancel_no_done got %0d exp 0", dcnt); end
    trigger = 1'b1; blink_num = 4'd1;
    dcnt = 0;
    for (int c = 0; c < 3050; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      checks++;
      if ({led_out, busy, done} !== {exp_led, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL cancel_restart cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                                   c, led_out, busy, done, exp_led, exp_busy, exp_done);
      end
      bcnt += int'(busy); lcnt += int'(led_out); dcnt += int'(done);
    end
    checks++;
    if (bcnt != PER || lcnt != ON_C || dcnt != 1) begin
      errors++;
      $display("FAIL cancel_restart_shape got busy %0d lit %0d done %0d exp %0d %0d 1", bcnt, lcnt, dcnt, PER, ON_C);
    end
  endtask

  task automatic test_async_reset();
    trigger = 1'b1; blink_num = 4'd1;
    for (int c = 0; c <= 1000; c++) begin
      @(negedge clk);
      trigger = 1'b0;
    end
    checks++;
    if ({led_out, busy} !== 2'b11) begin errors++; $display("FAIL async_reset_pre got led/busy %b%b exp 11", led_out, busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led_out, busy, done, led_out_al} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset_now got led/busy/done/led_al %b%b%b%b exp 0001", led_out, busy, done, led_out_al);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ({led_out, busy, done} !== 3'b000) begin
        errors++;
        if (errors <= 20) $display("FAIL async_reset_idle cyc %0d got %b%b%b exp 000", c, led_out, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bcnt = 0; int dcnt = 0; int d1 = -1; int s2 = -1; bit launched = 1'b0;
    trigger = 1'b1; blink_num = 4'd1;
    for (int c = 0; c < 6050; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      checks++;
      if ({led_out, busy, done} !== {exp_led, exp_busy, exp_done}) begin
        errors++;
        if (errors <= 20) $display("FAIL back_to_back cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                                   c, led_out, busy, done, exp_led, exp_busy, exp_done);
      end
      bcnt += int'(busy); dcnt += int'(done);
      if (launched && s2 < 0 && busy) s2 = c;
      if (done && !launched) begin
        d1 = c; launched = 1'b1;
        trigger = 1'b1; blink_num = 4'd1;
      end
    end
    checks++;
    if (d1 < 0 || s2 != d1 + 1) begin errors++; $display("FAIL back_to_back_gap got done %0d restart %0d exp restart=done+1", d1, s2); end
    checks++;
    if (bcnt != 2 * PER || dcnt != 2) begin
      errors++;
      $display("FAIL back_to_back_totals got busy %0d done %0d exp %0d 2", bcnt, dcnt, 2 * PER);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n; int bcnt; int dcnt; int rises; logic prev_led;
      n = $urandom_range(1, 3);
      bcnt = 0; dcnt = 0; rises = 0; prev_led = 1'b0;
      exp_q.push_back(CNT_W'(n));
      trigger = 1'b1; blink_num = CNT_W'(n);
      for (int c = 0; c < n * PER + 20; c++) begin
        @(negedge clk);
        // stray triggers while busy must be ignored
        trigger = exp_busy && ($urandom_range(0, 99) < 3);
        blink_num = CNT_W'($urandom_range(0, 15));
        checks++;
        if ({led_out, busy, done} !== {exp_led, exp_busy, exp_done}) begin
          errors++;
          if (errors <= 20) $display("FAIL random run %0d cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                                     r, c, led_out, busy, done, exp_led, exp_busy, exp_done);
        end
        bcnt += int'(busy); dcnt += int'(done);
        if (led_out && !prev_led) rises++;
        prev_led = led_out;
      end
      trigger = 1'b0;
      checks++;
      if (bcnt != n * PER || dcnt != 1 || rises != int'(exp_q.pop_front())) begin
        errors++;
        $display("FAIL random_run %0d got busy %0d done %0d blinks %0d exp %0d 1 %0d", r, bcnt, dcnt, rises, n * PER, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_blinks();
    test_blink_zero();
    test_ignore_retrigger();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Output-side counterpart to the button debouncer. It turns a one-cycle event pulse, such as a debounced button edge or a status event, into a human-visible LED blink sequence. The sequence is N blinks, each with a fixed ON time and a fixed OFF time, specified in milliseconds at the system clock. It sits between control logic and board LED pins, and reports busy and completion to the requester.

Parameters:
N, 32, width of the phase timer in bits.
FREQ, 100, clock frequency in MHz.
ON_TIME, 100, LED on duration in ms; ON_CYCLES = ON_TIME*1000*FREQ.
OFF_TIME, 100, LED off duration in ms; OFF_CYCLES = OFF_TIME*1000*FREQ.
CNT_W, 4, width of the blink count.
LED_ACTIVE_LOW, 0, 1 = led_out is driven 0 when lit.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
trigger  input  1  single-cycle start request.
blink_num  input  CNT_W  number of blinks; sampled only when trigger is accepted.
cancel  input  1  synchronous abort of a running sequence.
led_out  output  1  LED drive, polarity per LED_ACTIVE_LOW.
busy  output  1  high while a sequence is running.
done  output  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state IDLE; timer 0; remaining count 0.
  - busy=0, done=0.
  - led_out = unlit level: 0, or 1 if LED_ACTIVE_LOW=1.
- Reset asserted mid-sequence returns all of the above immediately, without waiting for a clock edge.
- All outputs are registered.
- States:
  - IDLE: LED unlit.
  - ON: LED lit.
  - OFF: LED unlit.
- IDLE -> ON:
  - Condition: edge where trigger=1, blink_num!=0 and cancel=0.
  - At that edge: remaining <= blink_num, timer <= 0, busy <= 1, led_out <= lit.
- Trigger ignored (no state change, busy stays 0):
  - trigger=1 with blink_num=0 in IDLE.
- ON phase:
  - Timer increments every cycle.
  - At the edge where timer==ON_CYCLES-1: state <= OFF, timer <= 0, led_out <= unlit, remaining <= remaining-1.
  - The LED is therefore lit for exactly ON_CYCLES clocks.
- OFF phase:
  - Timer increments every cycle.
  - At the edge where timer==OFF_CYCLES-1:
    - If remaining!=0: state <= ON, timer <= 0, led_out <= lit.
    - Otherwise: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle.
- The final OFF phase is always executed, so back-to-back sequences remain visibly separated.
- Total busy time = blink_num*(ON_CYCLES+OFF_CYCLES) cycles.
- trigger while busy=1 is ignored: not queued, and the running sequence is unaffected.
- A trigger in the same cycle that done pulses is accepted, because state is already IDLE at that edge.
- cancel=1 in ON or OFF, at the next edge:
  - state <= IDLE, timer <= 0, remaining <= 0, busy <= 0, led_out <= unlit.
  - done is NOT pulsed.
- cancel=1 together with trigger in IDLE: cancel wins and the sequence does not start.
- cancel in IDLE: no effect.
- Width rules:
  - The timer is N bits and compares against ON_CYCLES-1 / OFF_CYCLES-1 truncated to N bits.
  - ON_CYCLES and OFF_CYCLES must each be >= 1 and < 2^N (integrator's responsibility).
  - remaining is CNT_W bits; maximum is 2^CNT_W-1 blinks.
  - No counter ever wraps during legal operation.

Test Plan:
- Bench parameters: FREQ=1, ON_TIME=2, OFF_TIME=1, so ON=2000 and OFF=1000 cycles.
- Reset release, no trigger -> led_out=0, busy=0, done=0 held for 5000 cycles; with LED_ACTIVE_LOW=1, led_out=1.
- trigger with blink_num=3 -> led high 2000 / low 1000, repeated 3 times; busy high exactly 9000 cycles; done pulses once, 1 cycle wide, on the cycle busy falls.
- trigger with blink_num=0 -> no change: busy=0, led_out=0, done never pulses.
- blink_num=2 started, second trigger at cycle 500 with blink_num=5 -> ignored; exactly 2 blinks occur; busy=6000 cycles; done at end.
- blink_num=4 started, cancel at cycle 2500 (mid first OFF) -> next edge busy=0, led_out=0, no done; a following trigger with blink_num=1 yields a normal single 2000/1000 blink.
- blink_num=1 started; rst_n pulsed low at cycle 1000 -> led_out, busy and done go to 0 without a clock edge; after release the block stays in IDLE.
- Trigger with blink_num=1 asserted in the done cycle of a previous run -> the new sequence starts with no gap beyond that cycle.
